// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller.
//   seq_state_e  : sequencer FSM states
//   STAGE_*      : stage indices of the default five-stage pipeline
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_ISSUE,
    ST_WAIT,
    ST_TRAP
  } seq_state_e;

  localparam int unsigned STAGE_FETCH  = 0;
  localparam int unsigned STAGE_DECODE = 1;
  localparam int unsigned STAGE_EXEC   = 2;
  localparam int unsigned STAGE_MEM    = 3;
  localparam int unsigned STAGE_WRITE  = 4;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count at zero (wins over inc)
//   inc      : advance the count by one, saturating at all-ones
//   expired  : count has reached WDOG_LIMIT-1; never set when WDOG_LIMIT == 0
module stage_watchdog #(
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIM_M1 = WDOG_W'((WDOG_LIMIT > 0) ? WDOG_LIMIT - 1 : 0);

  if (longint'(WDOG_LIMIT) >= (longint'(1) << WDOG_W) || WDOG_LIMIT < 0) begin : g_bad_limit
    $error("stage_watchdog: WDOG_LIMIT does not fit in WDOG_W bits");
  end

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WDOG_W'(1);
    end
  end

  assign expired = (WDOG_LIMIT != 0) && (count >= LIM_M1);

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle core controller: walks N_STAGES stages with one-cycle enable
// pulses and done handshakes, owns the PC and retired counter, handles
// run/step/halt and traps a stage that never answers.
//   clk, rst     : clock, synchronous active-high reset
//   run          : level, free-run when high, halt after current instruction when low
//   step         : pulse, runs exactly one instruction from HALTED
//   stage_done   : done[k] from stage k (only the active stage's bit counts)
//   next_pc      : new PC, sampled with done of the last stage
//   stage_enable : one-hot one-cycle start pulse
//   pc           : PC of the instruction in flight
//   cur_stage    : active stage index
//   busy/halted  : instruction in flight / in HALTED
//   retired      : completed instructions (wraps)
//   trap         : sticky watchdog trap, trap_stage holds the hung stage
module stage_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int              N_STAGES   = 5,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              WDOG_W     = 16,
  parameter int              WDOG_LIMIT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        step,
  input  logic [N_STAGES-1:0]         stage_done,
  input  logic [PC_W-1:0]             next_pc,
  output logic [N_STAGES-1:0]         stage_enable,
  output logic [PC_W-1:0]             pc,
  output logic [$clog2(N_STAGES)-1:0] cur_stage,
  output logic                        busy,
  output logic                        halted,
  output logic [31:0]                 retired,
  output logic                        trap,
  output logic [$clog2(N_STAGES)-1:0] trap_stage
);

  localparam int SW = $clog2(N_STAGES);
  localparam logic [SW-1:0] LAST = SW'(N_STAGES - 1);

  if (N_STAGES < 2 || N_STAGES > 16) begin : g_bad_stages
    $error("stage_sequencer: N_STAGES must be in 2..16");
  end

  seq_state_e        state_q, state_d;
  logic              single_q, single_d;
  logic [SW-1:0]     stage_d;
  logic [PC_W-1:0]   pc_d;
  logic [31:0]       retired_d;
  logic              trap_d;
  logic [SW-1:0]     trap_stage_d;
  logic [N_STAGES-1:0] enable_d;
  logic              busy_d, halted_d;
  logic              wdog_expired;

  stage_watchdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d == ST_ISSUE),
    .inc     ((state_q == ST_ISSUE) || (state_q == ST_WAIT)),
    .expired (wdog_expired)
  );

  always_comb begin
    state_d      = state_q;
    stage_d      = cur_stage;
    single_d     = single_q;
    pc_d         = pc;
    retired_d    = retired;
    trap_d       = trap;
    trap_stage_d = trap_stage;

    unique case (state_q)
      ST_HALTED: begin
        if (run || step) begin
          state_d  = ST_ISSUE;
          stage_d  = '0;
          single_d = step && !run;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // done on the final watchdog cycle takes priority over the trap
        if (stage_done[cur_stage]) begin
          if (cur_stage == LAST) begin
            pc_d      = next_pc;
            retired_d = retired + 32'd1;
            stage_d   = '0;
            if (run && !single_q) begin
              state_d = ST_ISSUE;
            end else begin
              state_d  = ST_HALTED;
              single_d = 1'b0;
            end
          end else begin
            state_d = ST_ISSUE;
            stage_d = cur_stage + SW'(1);
          end
        end else if (wdog_expired) begin
          state_d      = ST_TRAP;
          trap_d       = 1'b1;
          trap_stage_d = cur_stage;
        end
      end
      ST_TRAP: ;
      default: state_d = ST_HALTED;
    endcase

    // Outputs are derived from the next state so they register alongside it
    enable_d = '0;
    if (state_d == ST_ISSUE) enable_d[stage_d] = 1'b1;
    busy_d   = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HALTED;
      single_q     <= 1'b0;
      cur_stage    <= '0;
      pc           <= RESET_PC;
      retired      <= '0;
      trap         <= 1'b0;
      trap_stage   <= '0;
      stage_enable <= '0;
      busy         <= 1'b0;
      halted       <= 1'b1;
    end else begin
      state_q      <= state_d;
      single_q     <= single_d;
      cur_stage    <= stage_d;
      pc           <= pc_d;
      retired      <= retired_d;
      trap         <= trap_d;
      trap_stage   <= trap_stage_d;
      stage_enable <= enable_d;
      busy         <= busy_d;
      halted       <= halted_d;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer. The bench plays every stage,
// answering each enable after a chosen latency, and tracks the expected PC,
// retired count and run/step outcome at the instruction level.
module tb_stage_sequencer;

  localparam int N   = 5;
  localparam int PW  = 32;
  localparam int SW  = $clog2(N);
  localparam int LIM = 8;
  localparam logic [PW-1:0] RPC = '0;

  logic          clk = 1'b0;
  logic          rst, run, step;
  logic [N-1:0]  stage_done;
  logic [PW-1:0] next_pc;
  logic [N-1:0]  stage_enable;
  logic [PW-1:0] pc;
  logic [SW-1:0] cur_stage;
  logic          busy, halted;
  logic [31:0]   retired;
  logic          trap;
  logic [SW-1:0] trap_stage;

  stage_sequencer #(
    .N_STAGES   (N),
    .PC_W       (PW),
    .RESET_PC   (RPC),
    .WDOG_W     (16),
    .WDOG_LIMIT (LIM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .step         (step),
    .stage_done   (stage_done),
    .next_pc      (next_pc),
    .stage_enable (stage_enable),
    .pc           (pc),
    .cur_stage    (cur_stage),
    .busy         (busy),
    .halted       (halted),
    .retired      (retired),
    .trap         (trap),
    .trap_stage   (trap_stage)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] exp_pc;
  logic [31:0]   exp_ret;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    onehot = '0;
    onehot[k] = 1'b1;
  endfunction

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  // Entered on the negedge showing ISSUE(k); leaves on the negedge after done[k] was taken
  task automatic do_stage(input int k, input int lat, input bit stray, input bit rand_ctl,
                          input bit drop, input logic [PW-1:0] npc, output bit run_final);
    check_eq("issue_enable", 64'(stage_enable), 64'(onehot(k)));
    check_eq("issue_stage", 64'(cur_stage), 64'(k));
    check_eq("issue_busy", 64'(busy), 64'(1));
    check_eq("issue_pc", 64'(pc), 64'(exp_pc));
    stage_done = stray ? {N{1'b1}} : {N{1'b0}};
    run_final = run;
    for (int j = 0; j < lat; j++) begin
      tick();
      check_eq("wait_enable", 64'(stage_enable), 64'(0));
      check_eq("wait_busy", 64'(busy), 64'(1));
      check_eq("wait_trap", 64'(trap), 64'(0));
      if (drop) begin
        run = 1'b0;
      end else if (rand_ctl) begin
        if ($urandom_range(0, 7) == 0) run = ~run;
        step = ($urandom_range(0, 3) == 0);
      end
      if (j == lat - 1) begin
        stage_done = stray ? {N{1'b1}} : onehot(k);
        next_pc    = npc;
      end else begin
        stage_done = stray ? ~onehot(k) : {N{1'b0}};
        next_pc    = $urandom;
      end
      run_final = run;
    end
    tick();
    stage_done = '0;
    step = 1'b0;
  endtask

  task automatic do_instr(input bit single, input int lat_fixed, input bit stray, input bit rand_ctl,
                          input int drop_k, input int long_k, input int long_lat, output bit cont);
    logic [PW-1:0] npc;
    bit rf;
    int lat;
    npc = '0;
    rf  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == long_k) lat = long_lat;
      else if (lat_fixed != 0) lat = lat_fixed;
      else lat = int'($urandom_range(1, LIM - 1));
      npc = (lat_fixed != 0) ? exp_pc + 32'd4 : $urandom;
      do_stage(k, lat, stray, rand_ctl, (drop_k >= 0) && (k >= drop_k), npc, rf);
    end
    exp_pc  = npc;
    exp_ret = exp_ret + 32'd1;
    check_eq("retire_pc", 64'(pc), 64'(exp_pc));
    check_eq("retire_count", 64'(retired), 64'(exp_ret));
    cont = rf && !single;
    if (!cont) begin
      check_eq("end_halted", 64'(halted), 64'(1));
      check_eq("end_enable", 64'(stage_enable), 64'(0));
      check_eq("end_busy", 64'(busy), 64'(0));
      check_eq("end_stage", 64'(cur_stage), 64'(0));
    end
  endtask

  task automatic start(input bit r, input bit s, output bit single);
    run = r;
    step = s;
    single = s && !r;
    tick();
    step = 1'b0;
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    step = 1'b0;
    repeat (n) begin
      tick();
      check_eq("idle_halted", 64'(halted), 64'(1));
      check_eq("idle_enable", 64'(stage_enable), 64'(0));
    end
  endtask

  initial begin
    bit sg, cont, rf, r, s, last;
    rst = 1'b1; run = 1'b0; step = 1'b0; stage_done = '0; next_pc = '0;
    exp_pc = RPC; exp_ret = '0;
    repeat (3) tick();
    check_eq("rst_enable", 64'(stage_enable), 64'(0));
    check_eq("rst_stage", 64'(cur_stage), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_halted", 64'(halted), 64'(1));
    check_eq("rst_pc", 64'(pc), 64'(RPC));
    check_eq("rst_retired", 64'(retired), 64'(0));
    check_eq("rst_trap", 64'(trap), 64'(0));
    check_eq("rst_trap_stage", 64'(trap_stage), 64'(0));
    rst = 1'b0;

    // Free run, latency 1, pc+4; second instruction drops run in stage 2 with stray dones
    start(1'b1, 1'b0, sg);
    do_instr(sg, 1, 1'b0, 1'b0, -1, -1, 0, cont);
    check_eq("freerun_cont_busy", 64'(busy), 64'(1));
    do_instr(1'b0, 3, 1'b1, 1'b0, 2, -1, 0, cont);
    idle(3);

    // Single step
    start(1'b0, 1'b1, sg);
    do_instr(sg, 1, 1'b0, 1'b0, -1, -1, 0, cont);
    idle(2);

    // done on the last watchdog cycle of stage 3 beats the trap
    start(1'b1, 1'b0, sg);
    do_instr(sg, 1, 1'b0, 1'b0, 0, 3, LIM - 1, cont);
    check_eq("wd_boundary_trap", 64'(trap), 64'(0));
    idle(1);

    // Randomised bursts
    for (int b = 0; b < 12; b++) begin
      r = ($urandom_range(0, 1) == 1);
      s = r ? ($urandom_range(0, 1) == 1) : 1'b1;
      start(r, s, sg);
      for (int i = 0; i < 4; i++) begin
        last = (i == 3);
        do_instr(sg, 0, ($urandom_range(0, 1) == 1), !last, last ? 0 : -1, -1, 0, cont);
        if (!cont) break;
        sg = 1'b0;
      end
      idle(2);
    end

    // Stage 3 never answers
    start(1'b1, 1'b0, sg);
    for (int k = 0; k < 3; k++) do_stage(k, 1, 1'b0, 1'b0, 1'b0, $urandom, rf);
    check_eq("wd_issue3", 64'(stage_enable), 64'(onehot(3)));
    for (int t = 1; t <= LIM; t++) begin
      tick();
      if (t < LIM) begin
        check_eq("wd_pretrap", 64'(trap), 64'(0));
      end else begin
        check_eq("wd_trap", 64'(trap), 64'(1));
        check_eq("wd_trap_stage", 64'(trap_stage), 64'(3));
        check_eq("wd_busy", 64'(busy), 64'(0));
        check_eq("wd_halted", 64'(halted), 64'(0));
        check_eq("wd_pc", 64'(pc), 64'(exp_pc));
      end
    end
    stage_done = '1;
    step = 1'b1;
    repeat (4) begin
      tick();
      check_eq("trap_sticky", 64'(trap), 64'(1));
      check_eq("trap_enable", 64'(stage_enable), 64'(0));
    end
    rst = 1'b1; stage_done = '0; step = 1'b0; run = 1'b0;
    tick();
    rst = 1'b0;
    exp_pc = RPC; exp_ret = '0;
    check_eq("trap_rst_trap", 64'(trap), 64'(0));
    check_eq("trap_rst_halted", 64'(halted), 64'(1));
    check_eq("trap_rst_pc", 64'(pc), 64'(RPC));

    // Reset collides with the final done
    start(1'b1, 1'b0, sg);
    for (int k = 0; k < 4; k++) do_stage(k, 1, 1'b0, 1'b0, 1'b0, $urandom, rf);
    check_eq("rstmid_issue4", 64'(stage_enable), 64'(onehot(4)));
    tick();
    stage_done = onehot(4);
    next_pc = 32'h100;
    rst = 1'b1;
    tick();
    rst = 1'b0; stage_done = '0; run = 1'b0;
    check_eq("rstmid_pc", 64'(pc), 64'(RPC));
    check_eq("rstmid_retired", 64'(retired), 64'(exp_ret));
    check_eq("rstmid_halted", 64'(halted), 64'(1));
    check_eq("rstmid_busy", 64'(busy), 64'(0));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised multicycle core controller: sequences N_STAGES execution stages (fetch, decode, exec, mem, write at the default of 5) with one-cycle enable pulses and per-stage done handshakes.
- Owns the architectural PC, a retired-instruction counter, run/halt/single-step control and a per-stage watchdog that traps hung stages.
- Sits at the top of the core; stage modules connect to its enable/done vectors.

Parameters:
N_STAGES, 5, number of sequenced stages (2..16)
PC_W, 32, PC width
RESET_PC, 0, PC value after reset
WDOG_W, 16, watchdog counter width
WDOG_LIMIT, 1024, cycles allowed per stage before trap; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
run  in  1  level; 1 = free-run, 0 = stop after the current instruction
step  in  1  pulse; while HALTED, execute exactly one instruction
stage_done  in  N_STAGES  done[k] from stage k; only the current stage's bit is honoured
next_pc  in  PC_W  PC computed by the last stage; sampled with done[N_STAGES-1]
stage_enable  out  N_STAGES  one-hot one-cycle start pulse
pc  out  PC_W  PC of the instruction in flight
cur_stage  out  $clog2(N_STAGES)  index of the active stage
busy  out  1  an instruction is in flight
halted  out  1  in HALTED state
retired  out  32  instructions completed, wraps at 2^32
trap  out  1  watchdog fired; sticky until rst
trap_stage  out  $clog2(N_STAGES)  stage that hung

Behaviour:
- Reset: one clock and a synchronous, active-high reset (rst).
  - On rst: state=HALTED, pc=RESET_PC, stage_enable=0, cur_stage=0, busy=0, halted=1, retired=0, trap=0, trap_stage=0, watchdog=0.
  - rst mid-instruction aborts it; no pc or retired update.
- All outputs are registered.
- States: HALTED, ISSUE(k), WAIT(k), TRAP.
- HALTED:
  - Leaves HALTED when run=1 or step=1.
  - Next cycle is ISSUE(0) with stage_enable[0]=1.
  - A step sets an internal single flag.
- ISSUE(k):
  - Lasts exactly one cycle; stage_enable has bit k set, all others 0; busy=1; cur_stage=k; watchdog cleared.
  - Next state is always WAIT(k).
  - done[k] asserted during ISSUE is ignored; stages have latency >=1.
- WAIT(k):
  - stage_enable=0; watchdog increments each cycle.
  - done[k]=1 and k<N_STAGES-1: next cycle is ISSUE(k+1).
  - done[k]=1 and k=N_STAGES-1:
    - pc<=next_pc and retired<=retired+1, both visible next cycle.
    - If run=1 and single=0: ISSUE(0), so fetch sees the new pc in the same cycle as its enable.
    - Otherwise: HALTED; single cleared, busy=0.
  - done bits other than k are ignored in every state.
  - WDOG_LIMIT!=0 and watchdog reaches WDOG_LIMIT-1 without done[k]: next cycle TRAP, trap=1, trap_stage=k.
  - done[k] in that same final cycle wins over the trap.
- Minimum instruction length: 2*N_STAGES cycles (10 at default).
- run falling mid-instruction: the instruction completes, then HALTED.
- step while busy or while run=1: ignored.
- TRAP: stage_enable=0, busy=0, halted=0, pc holds; exit only via rst.
- Watchdog: WDOG_W bits; saturates, never wraps.
- Elaboration checks: WDOG_LIMIT < 2^WDOG_W and N_STAGES in range, enforced by assertion.

Decomposition:
- Package core_ctrl_pkg: state enum (HALTED, ISSUE, WAIT, TRAP) and default-stage index constants (FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4).
- Sub-module stage_watchdog: clear/increment/saturate counter with a limit compare; outputs expired.

Test Plan:
- Reset, run=1, every stage answers done one cycle after its enable, next_pc=pc+4: enables pulse 0..4 in order; pc goes 0->4->8 at cycles 10 and 20 after release; retired=2 at cycle 20.
- Stray done: assert done[3] during WAIT(1) and done[1] during ISSUE(1) -> no advance; sequence waits for a genuine done[1].
- run=0 while in WAIT(2) -> instruction completes, pc updates, halted=1, stage_enable stays 0; step pulse -> exactly one more instruction, retired+1, halted again.
- WDOG_LIMIT=8, stage 3 never answers -> trap=1 and trap_stage=3 exactly 8 cycles after enable[3]; pc unchanged; only rst clears it.
- done[3] in cycle 7 of WAIT(3) with WDOG_LIMIT=8 -> no trap, ISSUE(4) follows.
- rst asserted during WAIT(4) with done[4]=1 and next_pc=0x100 -> pc=RESET_PC, retired unchanged from its pre-reset value of 0 after reset, halted=1.
